dir_input_queue: RTL

- Upstream input stage that turns raw board buttons into the 2-bit direction consumed by the snake head, replacing the bare 2-flop synchronisers and reversal check in the top level.
- Each button is synchronised and debounced, then edge-detected.
- Accepted presses are buffered in a small direction queue. One entry is applied per game tick, so two quick presses between ticks (e.g. up then left) both take effect.
- Runs on the 25 MHz pixel clock.

---
 rtl/snake_pkg.sv | 14 +
 rtl/btn_debounce.sv | 45 ++++
 rtl/dir_input_queue.sv | 98 +++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Direction encoding shared by the snake head and the input queue.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // Up/down and left/right differ only in the top bit.
    function automatic logic [1:0] dir_opposite(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser + debouncer + rising-edge detect; level follows raw after 2 + DEB_CYCLES cycles.
// No backpressure: rise is a 1-cycle pulse combinational from registered level/prev.
module btn_debounce #(
    parameter int DEB_CYCLES = 125000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= level;
            // The counter only advances while the synced input disagrees with level.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/dir_input_queue.sv
// Debounced buttons -> prioritised, reversal-filtered direction queue popped once per tick; press to q_count is DEB_CYCLES+3.
// No backpressure upstream: a legal press that finds the queue full (and no pop) is discarded with a drop pulse.
module dir_input_queue
    import snake_pkg::*;
#(
    parameter int DEB_CYCLES = 125000,
    parameter int QDEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_u,
    input  logic                      btn_d,
    input  logic                      btn_l,
    input  logic                      btn_r,
    input  logic                      tick,
    output logic [1:0]                dir,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      drop
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic       rise_u, rise_d, rise_l, rise_r;
    logic [3:0] lvl_unused;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_u (
        .clk(clk), .reset(reset), .raw(btn_u), .level(lvl_unused[0]), .rise(rise_u));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_d (
        .clk(clk), .reset(reset), .raw(btn_d), .level(lvl_unused[1]), .rise(rise_d));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
        .clk(clk), .reset(reset), .raw(btn_l), .level(lvl_unused[2]), .rise(rise_l));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
        .clk(clk), .reset(reset), .raw(btn_r), .level(lvl_unused[3]), .rise(rise_r));

    logic [1:0]    mem [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] newest_ptr;

    logic       press;
    logic [1:0] cand;
    logic [1:0] ref_dir;
    logic       legal;
    logic       full;
    logic       push;
    logic       pop;

    // Only the highest-priority simultaneous press survives; the rest are lost.
    always_comb begin
        press = 1'b1;
        cand  = DIR_UP;
        if (rise_u)      cand = DIR_UP;
        else if (rise_r) cand = DIR_RIGHT;
        else if (rise_d) cand = DIR_DOWN;
        else if (rise_l) cand = DIR_LEFT;
        else             press = 1'b0;
    end

    assign newest_ptr = wr_ptr - PW'(1);
    // Compare against where the snake will be heading once the queue drains.
    assign ref_dir    = (q_count != '0) ? mem[newest_ptr] : dir;
    assign legal      = press && (cand != ref_dir) && (cand != dir_opposite(ref_dir));
    assign full       = (q_count == CW'(QDEPTH));
    assign pop        = tick && (q_count != '0);
    assign push       = legal && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cand;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir     <= DIR_RIGHT;
            q_count <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            drop    <= 1'b0;
        end else begin
            drop <= legal && full && !pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                dir    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

endmodule
